uart_ctrl: RTL

Parametrised UART controller for the core's peripheral bus: 16x-oversampled RX/TX engines, configurable-depth byte FIFOs with fill counts, runtime-selectable frame format, and sticky receive-error flags with an interrupt output. Sits between the core's byte read/write interface and the `rx`/`tx` pins, as the next-generation UART path beside the RAM software upgrader.

---
 rtl/uart_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_ctrl.sv
// UART controller: 16x-oversampled TX/RX engines, byte FIFOs with fill counts, sticky RX errors, irq.
// Optional parity support is built when UART_CTRL_PARITY_EN is defined.

module uart_ctrl_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   cnt_reg, cnt_next;
  logic          full_reg, empty_reg;
  logic          do_push, do_pop;

  // Fullness is judged before a same-cycle pop, so a push into a full FIFO is always dropped.
  assign do_push = push & (cnt_reg != DEPTH_C);
  assign do_pop  = pop & (cnt_reg != '0);

  always_comb begin
    cnt_next = cnt_reg;
    case ({do_push, do_pop})
      2'b10:   cnt_next = cnt_reg + (AW+1)'(1);
      2'b01:   cnt_next = cnt_reg - (AW+1)'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      cnt_reg   <= cnt_next;
      full_reg  <= (cnt_next == DEPTH_C);
      empty_reg <= (cnt_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = empty_reg ? 8'h00 : mem[rd_ptr_reg];
  assign cnt   = cnt_reg;
  assign full  = full_reg;
  assign empty = empty_reg;
endmodule

module uart_ctrl #(
  parameter int TXFIFO_DEPTH = 16,
  parameter int RXFIFO_DEPTH = 16,
  parameter int RX_THRESH    = 1
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic [15:0]                     baud_div,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  input  logic                            two_stop,
  input  logic                            rx,
  output logic                            tx,
  input  logic                            wr_req,
  input  logic [7:0]                      wr_data,
  output logic                            wr_ready,
  input  logic                            rd_req,
  output logic [7:0]                      rd_data,
  output logic                            txfifo_full,
  output logic                            rxfifo_empty,
  output logic [$clog2(TXFIFO_DEPTH):0]   txfifo_cnt,
  output logic [$clog2(RXFIFO_DEPTH):0]   rxfifo_cnt,
  output logic                            tx_busy,
  input  logic                            err_clr,
  output logic                            rx_overrun,
  output logic                            rx_parity_err,
  output logic                            rx_frame_err,
  output logic                            irq
);
  localparam int RW = $clog2(RXFIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef UART_CTRL_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  logic par_en_cfg, par_odd_cfg;
`ifdef UART_CTRL_PARITY_EN
  assign par_en_cfg  = parity_en;
  assign par_odd_cfg = parity_odd;
`else
  assign par_en_cfg  = 1'b0;
  assign par_odd_cfg = 1'b0;
`endif

  // Shared oversample divider; >= guards against baud_div shrinking below the running count.
  logic [15:0] div_cnt_reg;
  logic        tick;
  assign tick = (div_cnt_reg >= baud_div);

  always_ff @(posedge clk) begin
    if (!rstb)     div_cnt_reg <= '0;
    else if (tick) div_cnt_reg <= '0;
    else           div_cnt_reg <= div_cnt_reg + 16'd1;
  end

  logic       tx_empty, tx_pop;
  logic [7:0] tx_head;

  uart_ctrl_fifo #(.DEPTH(TXFIFO_DEPTH)) u_txfifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (wr_req),
    .push_data (wr_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .cnt       (txfifo_cnt),
    .full      (txfifo_full),
    .empty     (tx_empty)
  );

  assign wr_ready = ~txfifo_full;

  state_t     tx_state_reg, tx_state_next;
  logic [3:0] tx_tick_reg, tx_tick_next;
  logic [2:0] tx_bit_reg, tx_bit_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic       tx_par_bit_reg, tx_par_bit_next;
  logic       tx_par_en_reg, tx_par_en_next;
  logic       tx_two_reg, tx_two_next;
  logic       tx_stop2_reg, tx_stop2_next;
  logic       tx_line_reg, tx_line_next;
  logic       tx_load;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      tx_state_reg   <= S_IDLE;
      tx_tick_reg    <= '0;
      tx_bit_reg     <= '0;
      tx_shift_reg   <= '0;
      tx_par_bit_reg <= 1'b0;
      tx_par_en_reg  <= 1'b0;
      tx_two_reg     <= 1'b0;
      tx_stop2_reg   <= 1'b0;
      tx_line_reg    <= 1'b1;
    end else begin
      tx_state_reg   <= tx_state_next;
      tx_tick_reg    <= tx_tick_next;
      tx_bit_reg     <= tx_bit_next;
      tx_shift_reg   <= tx_shift_next;
      tx_par_bit_reg <= tx_par_bit_next;
      tx_par_en_reg  <= tx_par_en_next;
      tx_two_reg     <= tx_two_next;
      tx_stop2_reg   <= tx_stop2_next;
      tx_line_reg    <= tx_line_next;
    end
  end

  always_comb begin
    tx_state_next   = tx_state_reg;
    tx_tick_next    = tx_tick_reg;
    tx_bit_next     = tx_bit_reg;
    tx_shift_next   = tx_shift_reg;
    tx_par_bit_next = tx_par_bit_reg;
    tx_par_en_next  = tx_par_en_reg;
    tx_two_next     = tx_two_reg;
    tx_stop2_next   = tx_stop2_reg;
    tx_load         = 1'b0;
    if (tick) begin
      if (tx_state_reg == S_IDLE) begin
        tx_load = ~tx_empty;
      end else begin
        tx_tick_next = tx_tick_reg + 4'd1;
        if (tx_tick_reg == 4'd15) begin
          case (tx_state_reg)
            S_START: begin
              tx_state_next = S_DATA;
              tx_bit_next   = 3'd0;
            end
            S_DATA: begin
              if (tx_bit_reg == 3'd7) begin
                tx_stop2_next = 1'b0;
`ifdef UART_CTRL_PARITY_EN
                tx_state_next = tx_par_en_reg ? S_PARITY : S_STOP;
`else
                tx_state_next = S_STOP;
`endif
              end else begin
                tx_bit_next   = tx_bit_reg + 3'd1;
                tx_shift_next = {1'b0, tx_shift_reg[7:1]};
              end
            end
`ifdef UART_CTRL_PARITY_EN
            S_PARITY: begin
              tx_state_next = S_STOP;
              tx_stop2_next = 1'b0;
            end
`endif
            S_STOP: begin
              // A queued byte starts straight out of the last stop bit, leaving no idle gap.
              if (tx_two_reg && !tx_stop2_reg) tx_stop2_next = 1'b1;
              else if (!tx_empty)              tx_load = 1'b1;
              else                             tx_state_next = S_IDLE;
            end
            default: tx_state_next = S_IDLE;
          endcase
        end
      end
    end
    if (tx_load) begin
      tx_state_next   = S_START;
      tx_tick_next    = 4'd0;
      tx_shift_next   = tx_head;
      tx_par_bit_next = (^tx_head) ^ par_odd_cfg;
      tx_par_en_next  = par_en_cfg;
      tx_two_next     = two_stop;
      tx_stop2_next   = 1'b0;
    end
  end

  always_comb begin
    tx_pop       = tx_load;
    tx_line_next = 1'b1;
    case (tx_state_next)
      S_START:  tx_line_next = 1'b0;
      S_DATA:   tx_line_next = tx_shift_next[0];
`ifdef UART_CTRL_PARITY_EN
      S_PARITY: tx_line_next = tx_par_bit_next;
`endif
      default:  tx_line_next = 1'b1;
    endcase
  end

  assign tx      = tx_line_reg;
  assign tx_busy = (tx_state_reg != S_IDLE);

  logic       rx_s1_reg, rx_s2_reg;
  state_t     rx_state_reg, rx_state_next;
  logic [3:0] rx_tick_reg, rx_tick_next;
  logic [2:0] rx_bit_reg, rx_bit_next;
  logic [7:0] rx_shift_reg, rx_shift_next;
  logic       rx_par_bit_reg, rx_par_bit_next;
  logic       rx_par_en_reg, rx_par_en_next;
  logic       rx_par_odd_reg, rx_par_odd_next;
  logic       rx_push, frame_set, par_set, ovr_set;
  logic       rx_full;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      rx_s1_reg      <= 1'b1;
      rx_s2_reg      <= 1'b1;
      rx_state_reg   <= S_IDLE;
      rx_tick_reg    <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_par_bit_reg <= 1'b0;
      rx_par_en_reg  <= 1'b0;
      rx_par_odd_reg <= 1'b0;
    end else begin
      rx_s1_reg      <= rx;
      rx_s2_reg      <= rx_s1_reg;
      rx_state_reg   <= rx_state_next;
      rx_tick_reg    <= rx_tick_next;
      rx_bit_reg     <= rx_bit_next;
      rx_shift_reg   <= rx_shift_next;
      rx_par_bit_reg <= rx_par_bit_next;
      rx_par_en_reg  <= rx_par_en_next;
      rx_par_odd_reg <= rx_par_odd_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    rx_tick_next    = rx_tick_reg;
    rx_bit_next     = rx_bit_reg;
    rx_shift_next   = rx_shift_reg;
    rx_par_bit_next = rx_par_bit_reg;
    rx_par_en_next  = rx_par_en_reg;
    rx_par_odd_next = rx_par_odd_reg;
    if (tick) begin
      rx_tick_next = rx_tick_reg + 4'd1;
      case (rx_state_reg)
        S_IDLE: begin
          if (!rx_s2_reg) begin
            rx_state_next   = S_START;
            rx_tick_next    = 4'd0;
            rx_par_en_next  = par_en_cfg;
            rx_par_odd_next = par_odd_cfg;
          end
        end
        S_START: begin
          // Mid-start check; a line back high here was a glitch.
          if (rx_tick_reg == 4'd7) begin
            rx_tick_next  = 4'd0;
            rx_bit_next   = 3'd0;
            rx_state_next = rx_s2_reg ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (rx_tick_reg == 4'd15) begin
            rx_shift_next = {rx_s2_reg, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) begin
`ifdef UART_CTRL_PARITY_EN
              rx_state_next = rx_par_en_reg ? S_PARITY : S_STOP;
`else
              rx_state_next = S_STOP;
`endif
            end else begin
              rx_bit_next = rx_bit_reg + 3'd1;
            end
          end
        end
`ifdef UART_CTRL_PARITY_EN
        S_PARITY: begin
          if (rx_tick_reg == 4'd15) begin
            rx_par_bit_next = rx_s2_reg;
            rx_state_next   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (rx_tick_reg == 4'd15) rx_state_next = S_IDLE;
        end
        default: rx_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_push   = tick && (rx_state_reg == S_STOP) && (rx_tick_reg == 4'd15);
    frame_set = rx_push && !rx_s2_reg;
`ifdef UART_CTRL_PARITY_EN
    par_set   = rx_push && rx_par_en_reg &&
                (rx_par_bit_reg != ((^rx_shift_reg) ^ rx_par_odd_reg));
`else
    par_set   = 1'b0;
`endif
    ovr_set   = rx_push && rx_full;
  end

  uart_ctrl_fifo #(.DEPTH(RXFIFO_DEPTH)) u_rxfifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (rx_push),
    .push_data (rx_shift_reg),
    .pop       (rd_req),
    .head      (rd_data),
    .cnt       (rxfifo_cnt),
    .full      (rx_full),
    .empty     (rxfifo_empty)
  );

  // Sticky flags: a set in the same cycle as err_clr wins.
  logic ovr_reg, par_err_reg, frame_err_reg;
  always_ff @(posedge clk) begin
    if (!rstb) begin
      ovr_reg       <= 1'b0;
      par_err_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      ovr_reg       <= ovr_set   | (ovr_reg & ~err_clr);
      par_err_reg   <= par_set   | (par_err_reg & ~err_clr);
      frame_err_reg <= frame_set | (frame_err_reg & ~err_clr);
    end
  end

  assign rx_overrun    = ovr_reg;
  assign rx_parity_err = par_err_reg;
  assign rx_frame_err  = frame_err_reg;
  assign irq = (rxfifo_cnt >= RW'(RX_THRESH)) | ovr_reg | par_err_reg | frame_err_reg;

`ifndef UART_CTRL_PARITY_EN
  logic unused_par;
  assign unused_par = ^{parity_en, parity_odd, tx_par_en_reg, tx_par_bit_reg,
                        rx_par_en_reg, rx_par_odd_reg, rx_par_bit_reg};
`endif
endmodule
